// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM states, config
// register addresses and the global-enable bit position.
package intc_pkg;

  localparam int unsigned CFG_W   = 8;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned GEN_BIT = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_SWSET  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

endpackage : intc_pkg

// File: rtl/int_priority_encoder.sv
// Fixed-priority arbiter: lowest set bit of eligible wins.
// Ports:
//   eligible : per-source eligible requests
//   any      : at least one request eligible
//   idx      : index of the winning (lowest) source
module int_priority_encoder
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic [N_SRC-1:0] eligible,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  // Scan high to low so the lowest set bit is the last assignment.
  always_comb begin
    idx = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) idx = ID_W'(i);
    end
  end

  assign any = |eligible;

endmodule : int_priority_encoder

// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller feeding the processor's single
// interrupt input. Latches rising edges, masks, arbitrates by fixed
// priority and handshakes ack / return-from-interrupt (no nesting).
// Ports:
//   clk, reset          : clock, async active-low reset
//   irq_src             : peripheral interrupt lines (rising edge = request)
//   cfg_we/addr/wdata   : config write port
//   cfg_rdata           : combinational config read data
//   cpu_int, vector     : registered request and branch target
//   cpu_ack, cpu_reti   : pipeline take / handler return pulses
//   active_id, busy     : source in flight, high while servicing
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC      = 4,
  parameter logic [7:0]  VEC_BASE   = 8'hF0,
  parameter logic [7:0]  VEC_STRIDE = 8'h04
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CFG_W-1:0] cfg_wdata,
  output logic [CFG_W-1:0] cfg_rdata,
  output logic             cpu_int,
  output logic [7:0]       vector,
  input  logic             cpu_ack,
  input  logic             cpu_reti,
  output logic [ID_W-1:0]  active_id,
  output logic             busy
);

  localparam logic [CFG_W-1:0] SRC_BITS  = CFG_W'((9'd1 << N_SRC) - 9'd1);
  localparam logic [CFG_W-1:0] MASK_BITS = SRC_BITS | (CFG_W'(1) << GEN_BIT);

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   mask_q, mask_d;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [N_SRC-1:0]   hist_q;
  logic               cpu_int_q, cpu_int_d;
  logic               busy_q, busy_d;
  logic [7:0]         vector_q, vector_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic               wr_mask, wr_pend, wr_swset;
  logic [N_SRC-1:0]   wdata_src;
  logic [N_SRC-1:0]   set_bits, clr_bits, ack_clr;
  logic [N_SRC-1:0]   elig_now;
  logic [CFG_W-1:0]   elig_next;
  logic               win_any;
  logic [ID_W-1:0]    win_idx;

  assign wr_mask   = cfg_we && (cfg_addr == ADDR_MASK);
  assign wr_pend   = cfg_we && (cfg_addr == ADDR_PEND);
  assign wr_swset  = cfg_we && (cfg_addr == ADDR_SWSET);
  assign wdata_src = N_SRC'(cfg_wdata);

  // Pending clear from an accepted acknowledge.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      ack_clr[i] = (state_q == REQ) && cpu_ack && (id_q == ID_W'(i));
    end
  end

  // Sets take precedence over clears on the same bit.
  assign set_bits = (irq_src & ~hist_q) | (wr_swset ? wdata_src : '0);
  assign clr_bits = (wr_pend ? wdata_src : '0) | ack_clr;
  assign pend_d   = (pend_q & ~clr_bits) | set_bits;
  assign mask_d   = wr_mask ? (cfg_wdata & MASK_BITS) : mask_q;

  assign elig_now  = pend_q & N_SRC'(mask_q) & {N_SRC{mask_q[GEN_BIT]}};
  // Withdrawal looks at next-cycle eligibility so a clear/mask write drops
  // the request one cycle later, while a same-cycle re-arm keeps it.
  assign elig_next = CFG_W'(pend_d & N_SRC'(mask_d) & {N_SRC{mask_d[GEN_BIT]}});

  int_priority_encoder #(
    .N_SRC (N_SRC)
  ) u_prio (
    .eligible (elig_now),
    .any      (win_any),
    .idx      (win_idx)
  );

  // Request / service sequencer.
  always_comb begin
    state_d   = state_q;
    cpu_int_d = cpu_int_q;
    busy_d    = busy_q;
    vector_d  = vector_q;
    id_d      = id_q;
    case (state_q)
      IDLE: begin
        cpu_int_d = 1'b0;
        busy_d    = 1'b0;
        if (win_any) begin
          state_d   = REQ;
          cpu_int_d = 1'b1;
          id_d      = win_idx;
          vector_d  = 8'(VEC_BASE + 8'(8'(win_idx) * VEC_STRIDE));
        end
      end
      REQ: begin
        if (cpu_ack) begin
          state_d   = SERVICE;
          cpu_int_d = 1'b0;
          busy_d    = 1'b1;
        end else if (!elig_next[id_q]) begin
          state_d   = IDLE;
          cpu_int_d = 1'b0;
        end
      end
      SERVICE: begin
        cpu_int_d = 1'b0;
        if (cpu_reti) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        cpu_int_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      pend_q    <= '0;
      hist_q    <= '0;
      cpu_int_q <= 1'b0;
      busy_q    <= 1'b0;
      vector_q  <= 8'h00;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      hist_q    <= irq_src;
      cpu_int_q <= cpu_int_d;
      busy_q    <= busy_d;
      vector_q  <= vector_d;
      id_q      <= id_d;
    end
  end

  // Config read mux.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK:   cfg_rdata = mask_q;
      ADDR_PEND:   cfg_rdata = CFG_W'(pend_q);
      ADDR_STATUS: cfg_rdata = {busy_q, state_q, 2'b00, id_q};
      default:     cfg_rdata = '0;
    endcase
  end

  assign cpu_int   = cpu_int_q;
  assign vector    = vector_q;
  assign active_id = id_q;
  assign busy      = busy_q;

endmodule : interrupt_controller

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus
// randomized traffic, checked every cycle against a behavioural model.
module tb_interrupt_controller;

  localparam int N      = 4;
  localparam int VBASE  = 'hF0;
  localparam int VSTEP  = 'h04;
  localparam int SRCM   = (1 << N) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       cpu_int;
  logic [7:0] vector;
  logic       cpu_ack;
  logic       cpu_reti;
  logic [2:0] active_id;
  logic       busy;

  interrupt_controller #(
    .N_SRC      (N),
    .VEC_BASE   (8'hF0),
    .VEC_STRIDE (8'h04)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .cpu_int   (cpu_int),
    .vector    (vector),
    .cpu_ack   (cpu_ack),
    .cpu_reti  (cpu_reti),
    .active_id (active_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pending/mask as integers, phase 0=idle 1=req 2=service.
  int m_pend, m_mask, m_hist, m_state, m_int, m_vec, m_id, m_busy;
  int nx_pend, nx_mask, nx_hist, nx_state, nx_int, nx_vec, nx_id, nx_busy;

  task automatic m_reset();
    m_pend = 0; m_mask = 0; m_hist = 0; m_state = 0;
    m_int = 0; m_vec = 0; m_id = 0; m_busy = 0;
  endtask

  function automatic int enabled(input int p, input int m);
    return m[7] ? (p & m & SRCM) : 0;
  endfunction

  function automatic int lowest(input int v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int m_rdata();
    case (int'(cfg_addr))
      0: return m_mask;
      1: return m_pend;
      3: return (m_busy << 7) | (m_state << 5) | m_id;
      default: return 0;
    endcase
  endfunction

  task automatic m_next();
    int wd, set, clr, w;
    wd  = int'(cfg_wdata);
    set = int'(irq_src) & ~m_hist & SRCM;
    clr = 0;
    if (cfg_we && cfg_addr == 2'd2) set |= wd & SRCM;
    if (cfg_we && cfg_addr == 2'd1) clr = wd & SRCM;
    if (m_state == 1 && cpu_ack) clr |= (1 << m_id);
    nx_pend = (m_pend & ~clr) | set;
    nx_mask = (cfg_we && cfg_addr == 2'd0) ? (wd & ('h80 | SRCM)) : m_mask;
    nx_hist = int'(irq_src);
    nx_state = m_state; nx_int = m_int; nx_busy = m_busy; nx_vec = m_vec; nx_id = m_id;
    case (m_state)
      0: begin
        nx_int = 0; nx_busy = 0;
        w = lowest(enabled(m_pend, m_mask));
        if (w >= 0) begin
          nx_state = 1; nx_int = 1; nx_id = w;
          nx_vec = (VBASE + w * VSTEP) % 256;
        end
      end
      1: begin
        if (cpu_ack) begin
          nx_state = 2; nx_int = 0; nx_busy = 1;
        end else if (((enabled(nx_pend, nx_mask) >> m_id) & 1) == 0) begin
          nx_state = 0; nx_int = 0;
        end
      end
      default: begin
        nx_int = 0;
        if (cpu_reti) begin nx_state = 0; nx_busy = 0; end
      end
    endcase
  endtask

  // One clock: check read data, advance DUT and model, check outputs.
  task automatic cycle();
    #1;
    m_next();
    check_eq("cfg_rdata", cfg_rdata, m_rdata());
    @(posedge clk);
    #1;
    m_pend = nx_pend; m_mask = nx_mask; m_hist = nx_hist; m_state = nx_state;
    m_int = nx_int; m_vec = nx_vec; m_id = nx_id; m_busy = nx_busy;
    check_eq("cpu_int", cpu_int, m_int);
    check_eq("vector", vector, m_vec);
    check_eq("active_id", active_id, m_id);
    check_eq("busy", busy, m_busy);
    cfg_we = 1'b0; cpu_ack = 1'b0; cpu_reti = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cycle();
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input int exp);
    cfg_addr = a;
    #1;
    check_eq(tag, cfg_rdata, exp);
  endtask

  initial begin
    reset = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cpu_ack = 1'b0; cpu_reti = 1'b0;
    m_reset();
    #2;
    check_eq("rst_cpu_int", cpu_int, 0);
    check_eq("rst_vector", vector, 0);
    check_eq("rst_busy", busy, 0);
    #10 reset = 1'b1;

    // Basic request / ack / return on source 0
    wr(2'd0, 8'h81);
    irq_src = 4'b0001; cycle();
    irq_src = 4'b0000; cycle();
    check_eq("t1_int", cpu_int, 1);
    check_eq("t1_vec", vector, 'hF0);
    check_eq("t1_id", active_id, 0);
    cpu_ack = 1'b1; cycle();
    check_eq("t1_ack_int", cpu_int, 0);
    check_eq("t1_ack_busy", busy, 1);
    read_chk("t1_pend", 2'd1, 0);
    cpu_reti = 1'b1; cycle();
    check_eq("t1_reti_busy", busy, 0);

    // Simultaneous edges: lower index first, the other 2 cycles after reti
    wr(2'd0, 8'h8F);
    irq_src = 4'b1010; cycle();
    irq_src = 4'b0000; cycle();
    check_eq("t2_vec1", vector, 'hF4);
    check_eq("t2_id1", active_id, 1);
    cpu_ack = 1'b1; cycle();
    cpu_reti = 1'b1; cycle();
    check_eq("t2_int_after_reti", cpu_int, 0);
    cycle();
    check_eq("t2_int2", cpu_int, 1);
    check_eq("t2_vec2", vector, 'hFC);
    check_eq("t2_id2", active_id, 3);
    cpu_ack = 1'b1; cycle();
    cpu_reti = 1'b1; cycle();

    // Global enable off holds the request pending
    wr(2'd0, 8'h0F);
    irq_src = 4'b0100; cycle();
    irq_src = 4'b0000; cycle();
    cycle();
    check_eq("t3_int_masked", cpu_int, 0);
    read_chk("t3_pend", 2'd1, 'h04);
    wr(2'd0, 8'h8F);
    check_eq("t3_int_wait", cpu_int, 0);
    cycle();
    check_eq("t3_int", cpu_int, 1);
    check_eq("t3_vec", vector, 'hF8);

    // Withdrawal by W1C, then W1C racing a fresh edge
    wr(2'd1, 8'h04);
    check_eq("t4_withdraw", cpu_int, 0);
    cycle();
    irq_src = 4'b0100; cycle();
    irq_src = 4'b0000; cycle();
    check_eq("t4_req_again", cpu_int, 1);
    irq_src = 4'b0100; wr(2'd1, 8'h04);
    check_eq("t4_set_wins_int", cpu_int, 1);
    read_chk("t4_set_wins_pend", 2'd1, 'h04);
    irq_src = 4'b0000;
    cpu_ack = 1'b1; cycle();
    cpu_reti = 1'b1; cycle();

    // Edges during service, then async reset mid-request
    irq_src = 4'b0001; cycle();
    irq_src = 4'b0000; cycle();
    cpu_ack = 1'b1; cycle();
    irq_src = 4'b0001; wr(2'd2, 8'h02);
    check_eq("t5_int_in_service", cpu_int, 0);
    read_chk("t5_pend", 2'd1, 'h03);
    cpu_reti = 1'b1; cycle();
    cycle();
    check_eq("t5_int", cpu_int, 1);
    check_eq("t5_id", active_id, 0);
    irq_src = 4'b0000;
    reset = 1'b0;
    #1;
    m_reset();
    check_eq("t5_rst_int", cpu_int, 0);
    check_eq("t5_rst_vec", vector, 0);
    check_eq("t5_rst_id", active_id, 0);
    check_eq("t5_rst_busy", busy, 0);
    read_chk("t5_rst_pend", 2'd1, 0);
    reset = 1'b1;

    // Spurious handshakes and a long level-high source
    cpu_ack = 1'b1; cycle();
    check_eq("t6_ack_idle", busy, 0);
    wr(2'd0, 8'h8F);
    irq_src = 4'b0010; cycle();
    cycle();
    check_eq("t6_req", cpu_int, 1);
    cpu_reti = 1'b1; cycle();
    check_eq("t6_reti_in_req", cpu_int, 1);
    cpu_ack = 1'b1; cycle();
    check_eq("t6_busy", busy, 1);
    repeat (16) cycle();
    read_chk("t6_level_once", 2'd1, 0);
    cpu_reti = 1'b1; cycle();
    irq_src = 4'b0000; cycle();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      irq_src  = irq_src ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      cfg_addr = 2'($urandom);
      if (r < 12) begin
        cfg_we    = 1'b1;
        cfg_wdata = 8'($urandom);
        if (cfg_addr == 2'd0 && r < 10) cfg_wdata[7] = 1'b1;
      end
      cpu_ack  = (m_int == 1 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 19) == 0);
      cpu_reti = (m_busy == 1 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_interrupt_controller
